// File: rtl/multdiv_ctrl.sv
// Multicycle signed multiply (radix-2 Booth) / divide (restoring) controller, 32 steps per op.
// Optional macro MULTDIV_EARLY_ZERO_EN finishes in one step when an operand makes the result 0.
module multdiv_ctrl (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        stall
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StMult = 2'd1;
  localparam logic [1:0] StDiv  = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [32:0] acc_q, acc_d;
  logic [31:0] q_q, q_d;
  logic        qm1_q, qm1_d;
  logic [31:0] m_q, m_d;
  logic        neg_q, neg_d;
  logic        dz_q, dz_d;
  logic [31:0] result_q, result_d;
  logic        exc_q, exc_d;
  logic        early_zero;

`ifdef MULTDIV_EARLY_ZERO_EN
  logic ez_q, ez_d;
  assign early_zero = ez_q && (cnt_q == 6'd0);
`else
  assign early_zero = 1'b0;
`endif

  logic        busy;
  logic        start;
  logic        last_step;
  logic [31:0] a_mag, b_mag;
  logic [32:0] booth_add, booth_sum, b_acc;
  logic [31:0] b_q;
  logic [32:0] rem_sh, diff, d_acc;
  logic [31:0] d_q, d_res;
  logic        d_ok;

  assign busy      = (state_q == StMult) || (state_q == StDiv);
  assign start     = !busy && (ctrl_MULT || ctrl_DIV);
  assign last_step = (cnt_q == 6'd31);
  assign a_mag     = data_operandA[31] ? -data_operandA : data_operandA;
  assign b_mag     = data_operandB[31] ? -data_operandB : data_operandB;

  // Booth step: 33-bit accumulator absorbs the add of a negated 0x80000000 multiplicand.
  always_comb begin
    booth_add = 33'd0;
    case ({q_q[0], qm1_q})
      2'b01:   booth_add = {m_q[31], m_q};
      2'b10:   booth_add = -{m_q[31], m_q};
      default: booth_add = 33'd0;
    endcase
  end
  assign booth_sum = acc_q + booth_add;
  assign b_acc     = {booth_sum[32], booth_sum[32:1]};
  assign b_q       = {booth_sum[0], q_q[31:1]};

  // Restoring step on magnitudes; the remainder lives in acc_q, the quotient shifts into q_q.
  assign rem_sh = {acc_q[31:0], q_q[31]};
  assign diff   = rem_sh - {1'b0, m_q};
  assign d_ok   = !diff[32];
  assign d_acc  = d_ok ? diff : rem_sh;
  assign d_q    = {q_q[30:0], d_ok};
  assign d_res  = neg_q ? -d_q : d_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    q_d      = q_q;
    qm1_d    = qm1_q;
    m_d      = m_q;
    neg_d    = neg_q;
    dz_d     = dz_q;
    result_d = result_q;
    exc_d    = exc_q;
`ifdef MULTDIV_EARLY_ZERO_EN
    ez_d     = ez_q;
`endif
    case (state_q)
      StMult: begin
        if (early_zero) begin
          state_d  = StDone;
          result_d = 32'd0;
          exc_d    = 1'b0;
        end else begin
          acc_d = b_acc;
          q_d   = b_q;
          qm1_d = q_q[0];
          cnt_d = cnt_q + 6'd1;
          if (last_step) begin
            state_d  = StDone;
            result_d = b_q;
            exc_d    = (b_acc[31:0] != {32{b_q[31]}});
          end
        end
      end
      StDiv: begin
        if (dz_q) begin
          state_d  = StDone;
          result_d = 32'd0;
          exc_d    = 1'b1;
        end else if (early_zero) begin
          state_d  = StDone;
          result_d = 32'd0;
          exc_d    = 1'b0;
        end else begin
          acc_d = d_acc;
          q_d   = d_q;
          cnt_d = cnt_q + 6'd1;
          if (last_step) begin
            state_d  = StDone;
            result_d = d_res;
            exc_d    = !neg_q && d_q[31];
          end
        end
      end
      default: begin
        state_d = StIdle;
        if (start) begin
          cnt_d = 6'd0;
          acc_d = 33'd0;
          qm1_d = 1'b0;
          dz_d  = !ctrl_MULT && (data_operandB == 32'd0);
`ifdef MULTDIV_EARLY_ZERO_EN
          ez_d  = (data_operandA == 32'd0) || (ctrl_MULT && (data_operandB == 32'd0));
`endif
          if (ctrl_MULT) begin
            state_d = StMult;
            q_d     = data_operandB;
            m_d     = data_operandA;
            neg_d   = 1'b0;
          end else begin
            state_d = StDiv;
            q_d     = a_mag;
            m_d     = b_mag;
            neg_d   = data_operandA[31] ^ data_operandB[31];
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= 6'd0;
      acc_q    <= 33'd0;
      q_q      <= 32'd0;
      qm1_q    <= 1'b0;
      m_q      <= 32'd0;
      neg_q    <= 1'b0;
      dz_q     <= 1'b0;
      result_q <= 32'd0;
      exc_q    <= 1'b0;
`ifdef MULTDIV_EARLY_ZERO_EN
      ez_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      q_q      <= q_d;
      qm1_q    <= qm1_d;
      m_q      <= m_d;
      neg_q    <= neg_d;
      dz_q     <= dz_d;
      result_q <= result_d;
      exc_q    <= exc_d;
`ifdef MULTDIV_EARLY_ZERO_EN
      ez_q     <= ez_d;
`endif
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = (state_q == StDone);
  assign stall          = busy || ctrl_MULT || ctrl_DIV;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Randomized bench for multdiv_ctrl against a 64-bit arithmetic reference model.
module tb_multdiv_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        ctrl_MULT = 1'b0;
  logic        ctrl_DIV = 1'b0;
  logic [31:0] data_operandA = 32'd0;
  logic [31:0] data_operandB = 32'd0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        stall;

  int n_checks = 0;
  int n_pass   = 0;

  multdiv_ctrl dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .stall          (stall)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference: exact 64-bit arithmetic, overflow judged by range of the true result.
  function automatic void ref_op(input bit is_mult, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic e, output int lat);
    logic signed [63:0] sa, sb, p;
    sa  = 64'(signed'(a));
    sb  = 64'(signed'(b));
    lat = 32;
    if (is_mult) begin
      p = sa * sb;
      r = p[31:0];
      e = (p > 64'sd2147483647) || (p < -64'sd2147483648);
`ifdef MULTDIV_EARLY_ZERO_EN
      if (a == 32'd0 || b == 32'd0) lat = 1;
`endif
    end else if (b == 32'd0) begin
      r   = 32'd0;
      e   = 1'b1;
      lat = 1;
    end else begin
      p = sa / sb;
      r = p[31:0];
      e = (p > 64'sd2147483647);
`ifdef MULTDIV_EARLY_ZERO_EN
      if (a == 32'd0) lat = 1;
`endif
    end
  endfunction

  // Called on a negedge; returns on the negedge inside DONE so the next call can start back-to-back.
  task automatic run_op(input string tag, input bit m, input bit d, input logic [31:0] a,
                        input logic [31:0] b, input int pulse_at);
    logic [31:0] er;
    logic        ee;
    int          elat;
    int          seen;
    int          stall_bad;
    ref_op(m, a, b, er, ee, elat);
    ctrl_MULT     = m;
    ctrl_DIV      = d;
    data_operandA = a;
    data_operandB = b;
    #1 check_eq({tag, ".stall_req"}, 32'(stall), 32'd1);
    @(negedge clock);
    stall_bad = stall ? 0 : 1;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
    seen = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clock);
      if (data_resultRDY) begin
        seen = cyc;
        break;
      end
      if (!stall) stall_bad++;
      ctrl_DIV      = (cyc == pulse_at);
      data_operandA = $urandom;
      data_operandB = $urandom;
    end
    ctrl_DIV = 1'b0;
    check_eq({tag, ".latency"}, 32'(seen), 32'(elat));
    check_eq({tag, ".result"}, data_result, er);
    check_eq({tag, ".exception"}, 32'(data_exception), 32'(ee));
    check_eq({tag, ".stall_busy"}, 32'(stall_bad), 32'd0);
    check_eq({tag, ".stall_done"}, 32'(stall), 32'd0);
  endtask

  task automatic idle_gap(input string tag);
    logic [31:0] held;
    held = data_result;
    @(negedge clock);
    check_eq({tag, ".rdy_one_cycle"}, 32'(data_resultRDY), 32'd0);
    check_eq({tag, ".result_held"}, data_result, held);
  endtask

  initial begin
    int rdy_cnt;
    logic [31:0] ra, rb;
    #1 reset = 1'b1;
    #1;
    check_eq("rst.result", data_result, 32'd0);
    check_eq("rst.exception", 32'(data_exception), 32'd0);
    check_eq("rst.rdy", 32'(data_resultRDY), 32'd0);
    check_eq("rst.stall", 32'(stall), 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    run_op("mul_7x-3", 1'b1, 1'b0, 32'd7, -32'sd3, 0);
    idle_gap("mul_7x-3");
    run_op("mul_ovf", 1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 0);
    idle_gap("mul_ovf");
    run_op("div_-7/2", 1'b0, 1'b1, -32'sd7, 32'd2, 0);
    run_op("div_5/0", 1'b0, 1'b1, 32'd5, 32'd0, 0);
    idle_gap("div_5/0");
    run_op("both_hi", 1'b1, 1'b1, 32'd6, 32'd3, 10);
    idle_gap("both_hi");
    run_op("div_min/-1", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    idle_gap("div_min/-1");
    run_op("mul_0x5", 1'b1, 1'b0, 32'd0, 32'd5, 0);
    run_op("mul_9x9", 1'b1, 1'b0, 32'd9, 32'd9, 0);
    idle_gap("mul_9x9");

    // Abort a divide with reset partway through.
    ctrl_DIV      = 1'b1;
    data_operandA = 32'd100;
    data_operandB = 32'd7;
    @(negedge clock);
    ctrl_DIV = 1'b0;
    repeat (15) @(negedge clock);
    reset = 1'b1;
    #1;
    check_eq("midrst.result", data_result, 32'd0);
    check_eq("midrst.exception", 32'(data_exception), 32'd0);
    check_eq("midrst.rdy", 32'(data_resultRDY), 32'd0);
    check_eq("midrst.stall", 32'(stall), 32'd0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    rdy_cnt = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clock);
      if (data_resultRDY) rdy_cnt++;
    end
    check_eq("midrst.no_rdy", 32'(rdy_cnt), 32'd0);
    run_op("mul_2x3", 1'b1, 1'b0, 32'd2, 32'd3, 0);

    for (int n = 0; n < 40; n++) begin
      logic [31:0] v[2];
      for (int k = 0; k < 2; k++) begin
        case ($urandom_range(0, 5))
          0:       v[k] = 32'd0;
          1:       v[k] = 32'($urandom_range(0, 40)) - 32'd20;
          2:       v[k] = 32'h8000_0000;
          default: v[k] = $urandom;
        endcase
      end
      ra = v[0];
      rb = v[1];
      if ($urandom_range(0, 1) == 1) run_op("rand_mul", 1'b1, 1'($urandom_range(0, 1)), ra, rb, 0);
      else run_op("rand_div", 1'b0, 1'b1, ra, rb, 0);
      if ($urandom_range(0, 1) == 1) idle_gap("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
